// File: rtl/pulse_channel_pkg.sv
// Shared constants for the APU pulse voice: length lookup, duty waveforms, register map.
package pulse_channel_pkg;

  localparam int REG_CTRL  = 0;
  localparam int REG_SWEEP = 1;
  localparam int REG_LO    = 2;
  localparam int REG_HI    = 3;

  localparam int unsigned ENV_TICK_HZ = 240;
  localparam int unsigned LEN_TICK_HZ = 120;

  localparam int CTRL_LOOP_BIT  = 5;
  localparam int CTRL_CONST_BIT = 4;
  localparam int SWEEP_EN_BIT   = 7;
  localparam int SWEEP_NEG_BIT  = 3;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  // Bit [i] is the output level at sequencer index i.
  localparam logic [7:0] DUTY_PATTERN [4] = '{
    8'b00000010, 8'b00000110, 8'b00011110, 8'b11111001
  };

endpackage

// File: rtl/pulse_channel_if.sv
// Register-write strobes, frame ticks and sample output of one pulse voice.
interface pulse_channel_if #(
  parameter int unsigned VOL_W = 4
);
  logic             enable_240hz;
  logic             enable_120hz;
  logic             chan_en;
  logic [3:0]       wr;
  logic [7:0]       din;
  logic [VOL_W-1:0] pulse_out;
  logic             active;

  modport master (
    output enable_240hz, enable_120hz, chan_en, wr, din,
    input  pulse_out, active
  );

  modport slave (
    input  enable_240hz, enable_120hz, chan_en, wr, din,
    output pulse_out, active
  );
endinterface

// File: rtl/pulse_channel_envelope.sv
// Envelope generator: start flag, divider and decay counter, clocked by the 240 Hz tick.
module pulse_channel_envelope #(
  parameter int unsigned VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             loop,
  input  logic [VOL_W-1:0] vol,
  output logic [VOL_W-1:0] decay
);

  logic             start_q, start_d;
  logic [VOL_W-1:0] div_q, div_d;
  logic [VOL_W-1:0] decay_q, decay_d;

  always_comb begin
    start_d = start_q;
    div_d   = div_q;
    decay_d = decay_q;
    if (tick) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = '1;
        div_d   = vol;
      end else if (div_q == '0) begin
        div_d = vol;
        if (decay_q != '0) begin
          decay_d = decay_q - VOL_W'(1);
        end else if (loop) begin
          decay_d = '1;
        end
      end else begin
        div_d = div_q - VOL_W'(1);
      end
    end
    // A new note arriving on the tick cycle must still restart the envelope.
    if (start) begin
      start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      div_q   <= '0;
      decay_q <= '0;
    end else begin
      start_q <= start_d;
      div_q   <= div_d;
      decay_q <= decay_d;
    end
  end

  assign decay = decay_q;

endmodule

// File: rtl/pulse_channel.sv
// NES-style pulse voice: timer, duty sequencer, envelope, sweep unit and length counter.
module pulse_channel
  import pulse_channel_pkg::*;
#(
  parameter int unsigned TIMER_W     = 11,
  parameter int unsigned VOL_W       = 4,
  parameter int unsigned LEN_W       = 8,
  parameter bit          NEGATE_ONES = 1'b1
) (
  input logic            clk,
  input logic            rst,
  pulse_channel_if.slave bus
);

  logic [1:0]         duty_q, duty_d;
  logic               halt_q, halt_d;
  logic               const_vol_q, const_vol_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic               sw_en_q, sw_en_d;
  logic [2:0]         sw_rate_q, sw_rate_d;
  logic               sw_neg_q, sw_neg_d;
  logic [2:0]         sw_shift_q, sw_shift_d;
  logic               sw_reload_q, sw_reload_d;
  logic [2:0]         sw_div_q, sw_div_d;
  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         seq_q, seq_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic               step_q, step_d;
  logic [VOL_W-1:0]   pulse_out_q, pulse_out_d;

  logic [VOL_W-1:0]   decay;
  logic [VOL_W-1:0]   volume;
  logic [TIMER_W-1:0] delta;
  logic [TIMER_W:0]   sum, diff, target;
  logic               mute;
  logic               active;
  logic               cpu_period_wr;
  logic [7:0]         pattern;

  pulse_channel_envelope #(
    .VOL_W (VOL_W)
  ) u_env (
    .clk   (clk),
    .rst   (rst),
    .tick  (bus.enable_240hz),
    .start (bus.wr[REG_HI]),
    .loop  (halt_q),
    .vol   (vol_q),
    .decay (decay)
  );

  assign volume = const_vol_q ? vol_q : decay;
  assign active = (length_q != '0);

  // Sweep target is one bit wider so upward overflow and downward borrow are both visible.
  assign delta  = period_q >> sw_shift_q;
  assign sum    = {1'b0, period_q} + {1'b0, delta};
  assign diff   = {1'b0, period_q} - {1'b0, delta} - (TIMER_W + 1)'(NEGATE_ONES);
  assign target = sw_neg_q ? (diff[TIMER_W] ? '0 : diff) : sum;
  assign mute   = (period_q < TIMER_W'(8)) || (!sw_neg_q && sum[TIMER_W]);

  assign cpu_period_wr = bus.wr[REG_LO] | bus.wr[REG_HI];
  assign pattern       = DUTY_PATTERN[duty_q];

  always_comb begin
    duty_d      = duty_q;
    halt_d      = halt_q;
    const_vol_d = const_vol_q;
    vol_d       = vol_q;
    sw_en_d     = sw_en_q;
    sw_rate_d   = sw_rate_q;
    sw_neg_d    = sw_neg_q;
    sw_shift_d  = sw_shift_q;
    sw_reload_d = sw_reload_q;
    sw_div_d    = sw_div_q;
    period_d    = period_q;
    timer_d     = timer_q;
    seq_d       = seq_q;
    length_d    = length_q;
    step_d      = 1'b0;
    pulse_out_d = pulse_out_q;

    if (bus.wr[REG_CTRL]) begin
      duty_d      = bus.din[7:6];
      halt_d      = bus.din[CTRL_LOOP_BIT];
      const_vol_d = bus.din[CTRL_CONST_BIT];
      vol_d       = VOL_W'(bus.din[3:0]);
    end

    if (bus.enable_120hz) begin
      if (sw_div_q == 3'd0 && sw_en_q && sw_shift_q != 3'd0 && !mute && !cpu_period_wr) begin
        period_d = target[TIMER_W-1:0];
      end
      if (sw_div_q == 3'd0 || sw_reload_q) begin
        sw_div_d    = sw_rate_q;
        sw_reload_d = 1'b0;
      end else begin
        sw_div_d = sw_div_q - 3'd1;
      end
    end

    if (bus.wr[REG_SWEEP]) begin
      sw_en_d     = bus.din[SWEEP_EN_BIT];
      sw_rate_d   = bus.din[6:4];
      sw_neg_d    = bus.din[SWEEP_NEG_BIT];
      sw_shift_d  = bus.din[2:0];
      sw_reload_d = 1'b1;
    end

    if (bus.wr[REG_LO]) begin
      period_d[7:0] = bus.din;
    end
    if (bus.wr[REG_HI]) begin
      period_d[TIMER_W-1:8] = bus.din[TIMER_W-9:0];
    end

    if (timer_q == '0) begin
      timer_d = period_q;
      seq_d   = seq_q - 3'd1;
      step_d  = 1'b1;
    end else begin
      timer_d = timer_q - TIMER_W'(1);
    end
    if (bus.wr[REG_HI]) begin
      seq_d  = 3'd0;
      step_d = 1'b1;
    end

    if (!bus.chan_en) begin
      length_d = '0;
    end else if (bus.wr[REG_HI]) begin
      length_d = LEN_W'(LEN_TABLE[bus.din[7:3]]);
    end else if (bus.enable_120hz && length_q != '0 && !halt_q) begin
      length_d = length_q - LEN_W'(1);
    end

    // Output only resamples after a sequencer step, so duty/volume edits land on step edges.
    if (step_q) begin
      pulse_out_d = (pattern[seq_q] && active && !mute) ? volume : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q      <= '0;
      halt_q      <= 1'b0;
      const_vol_q <= 1'b0;
      vol_q       <= '0;
      sw_en_q     <= 1'b0;
      sw_rate_q   <= '0;
      sw_neg_q    <= 1'b0;
      sw_shift_q  <= '0;
      sw_reload_q <= 1'b0;
      sw_div_q    <= '0;
      period_q    <= '0;
      timer_q     <= '0;
      seq_q       <= '0;
      length_q    <= '0;
      step_q      <= 1'b0;
      pulse_out_q <= '0;
    end else begin
      duty_q      <= duty_d;
      halt_q      <= halt_d;
      const_vol_q <= const_vol_d;
      vol_q       <= vol_d;
      sw_en_q     <= sw_en_d;
      sw_rate_q   <= sw_rate_d;
      sw_neg_q    <= sw_neg_d;
      sw_shift_q  <= sw_shift_d;
      sw_reload_q <= sw_reload_d;
      sw_div_q    <= sw_div_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
      seq_q       <= seq_d;
      length_q    <= length_d;
      step_q      <= step_d;
      pulse_out_q <= pulse_out_d;
    end
  end

  assign bus.pulse_out = pulse_out_q;
  assign bus.active    = active;

endmodule

// File: tb/tb_pulse_channel.sv
// Directed bench for pulse_channel: CH1 (ones' complement) and CH2 (two's) driven in lockstep.
module tb_pulse_channel;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  pulse_channel_if #(.VOL_W(4)) bus1 ();
  pulse_channel_if #(.VOL_W(4)) bus2 ();

  pulse_channel #(
    .TIMER_W     (11),
    .VOL_W       (4),
    .LEN_W       (8),
    .NEGATE_ONES (1'b1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  pulse_channel #(
    .TIMER_W     (11),
    .VOL_W       (4),
    .LEN_W       (8),
    .NEGATE_ONES (1'b0)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_chan_en(input logic en);
    bus1.chan_en = en;
    bus2.chan_en = en;
  endtask

  task automatic wr_reg(input int idx, input logic [7:0] data);
    @(negedge clk);
    bus1.wr  = 4'(1 << idx);
    bus2.wr  = 4'(1 << idx);
    bus1.din = data;
    bus2.din = data;
    @(negedge clk);
    bus1.wr = 4'b0;
    bus2.wr = 4'b0;
  endtask

  task automatic tick120(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus1.enable_120hz = 1'b1;
      bus2.enable_120hz = 1'b1;
      @(negedge clk);
      bus1.enable_120hz = 1'b0;
      bus2.enable_120hz = 1'b0;
    end
  endtask

  task automatic tick240(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus1.enable_240hz = 1'b1;
      bus2.enable_240hz = 1'b1;
      @(negedge clk);
      bus1.enable_240hz = 1'b0;
      bus2.enable_240hz = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus1.pulse_out !== 4'd0) begin n_bad++;
      $display("FAIL reset_pulse_out1: got %0d want 0", bus1.pulse_out); end
    n_cmp++; if (bus1.active !== 1'b0) begin n_bad++;
      $display("FAIL reset_active1: got %b want 0", bus1.active); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus2.pulse_out !== 4'd0) begin n_bad++;
      $display("FAIL reset_pulse_out2: got %0d want 0", bus2.pulse_out); end
    n_cmp++; if (bus2.active !== 1'b0) begin n_bad++;
      $display("FAIL reset_active2: got %b want 0", bus2.active); end
  endtask

  task automatic test_duty();
    int hi;
    int lo;
    bit found;
    logic [3:0] prev;
    do_reset();
    set_chan_en(1'b1);
    wr_reg(0, 8'hBF);
    wr_reg(2, 8'h10);
    wr_reg(3, 8'h08);
    n_cmp++; if (bus1.active !== 1'b1) begin n_bad++;
      $display("FAIL duty_active: got %b want 1", bus1.active); end
    found = 1'b0;
    prev  = bus1.pulse_out;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'd0 && bus1.pulse_out == 4'd15) found = 1'b1;
      prev = bus1.pulse_out;
    end
    n_cmp++; if (!found) begin n_bad++;
      $display("FAIL duty_rise: got no 0->15 edge want edge within 400 clks"); end
    hi = 0;
    while (bus1.pulse_out == 4'd15 && hi < 500) begin hi++; @(negedge clk); end
    lo = 0;
    while (bus1.pulse_out == 4'd0 && lo < 500) begin lo++; @(negedge clk); end
    n_cmp++; if (hi != 68) begin n_bad++;
      $display("FAIL duty_high_run: got %0d clks want 68", hi); end
    n_cmp++; if (lo != 68) begin n_bad++;
      $display("FAIL duty_low_run: got %0d clks want 68", lo); end
    n_cmp++; if (bus1.pulse_out !== 4'd15) begin n_bad++;
      $display("FAIL duty_next_high: got %0d want 15", bus1.pulse_out); end
  endtask

  task automatic test_reset_mid_note();
    int bad;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (bus1.pulse_out == 4'd15) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++;
      $display("FAIL midnote_playing: got no output 15 want note playing"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus1.pulse_out !== 4'd0) begin n_bad++;
      $display("FAIL midnote_silence: got %0d want 0", bus1.pulse_out); end
    n_cmp++; if (bus1.active !== 1'b0) begin n_bad++;
      $display("FAIL midnote_active: got %b want 0", bus1.active); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus1.pulse_out !== 4'd0 || bus1.active !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++;
      $display("FAIL midnote_hold: got %0d noisy clks want 0", bad); end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (bus1.active !== 1'b0 || bus1.pulse_out !== 4'd0) begin n_bad++;
      $display("FAIL midnote_after: got active=%b out=%0d want 0/0", bus1.active, bus1.pulse_out);
    end
  endtask

  task automatic test_mute();
    int bad;
    do_reset();
    set_chan_en(1'b1);
    wr_reg(0, 8'hBF);
    wr_reg(2, 8'h07);
    wr_reg(3, 8'h08);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus1.pulse_out !== 4'd0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++;
      $display("FAIL mute_low_period: got %0d nonzero clks want 0", bad); end
    n_cmp++; if (bus1.active !== 1'b1) begin n_bad++;
      $display("FAIL mute_low_active: got %b want 1", bus1.active); end
    wr_reg(1, 8'h81);
    wr_reg(2, 8'hF0);
    wr_reg(3, 8'h0F);
    tick120(1);
    n_cmp++; if (dut1.period_q !== 11'h7F0) begin n_bad++;
      $display("FAIL mute_ovf_period1: got %h want 7f0", dut1.period_q); end
    n_cmp++; if (dut2.period_q !== 11'h7F0) begin n_bad++;
      $display("FAIL mute_ovf_period2: got %h want 7f0", dut2.period_q); end
    n_cmp++; if (dut1.mute !== 1'b1) begin n_bad++;
      $display("FAIL mute_ovf_flag: got %b want 1", dut1.mute); end
  endtask

  task automatic test_sweep();
    do_reset();
    set_chan_en(1'b1);
    wr_reg(1, 8'h89);
    wr_reg(2, 8'h00);
    wr_reg(3, 8'h01);
    tick120(1);
    n_cmp++; if (dut1.period_q !== 11'h07F) begin n_bad++;
      $display("FAIL sweep_neg1_ch1: got %h want 07f", dut1.period_q); end
    n_cmp++; if (dut2.period_q !== 11'h080) begin n_bad++;
      $display("FAIL sweep_neg1_ch2: got %h want 080", dut2.period_q); end
    tick120(2);
    n_cmp++; if (dut1.period_q !== 11'h01F) begin n_bad++;
      $display("FAIL sweep_neg3_ch1: got %h want 01f", dut1.period_q); end
    n_cmp++; if (dut2.period_q !== 11'h020) begin n_bad++;
      $display("FAIL sweep_neg3_ch2: got %h want 020", dut2.period_q); end
    // CPU low-byte write lands on the same cycle as a sweep update.
    @(negedge clk);
    bus1.wr = 4'b0100; bus2.wr = 4'b0100;
    bus1.din = 8'h55;  bus2.din = 8'h55;
    bus1.enable_120hz = 1'b1; bus2.enable_120hz = 1'b1;
    @(negedge clk);
    bus1.wr = 4'b0; bus2.wr = 4'b0;
    bus1.enable_120hz = 1'b0; bus2.enable_120hz = 1'b0;
    n_cmp++; if (dut1.period_q !== 11'h055) begin n_bad++;
      $display("FAIL sweep_cpu_wins1: got %h want 055", dut1.period_q); end
    n_cmp++; if (dut2.period_q !== 11'h055) begin n_bad++;
      $display("FAIL sweep_cpu_wins2: got %h want 055", dut2.period_q); end
  endtask

  task automatic test_envelope();
    do_reset();
    set_chan_en(1'b1);
    wr_reg(0, 8'h03);
    wr_reg(3, 8'h08);
    tick240(1);
    n_cmp++; if (dut1.volume !== 4'd15) begin n_bad++;
      $display("FAIL env_start: got %0d want 15", dut1.volume); end
    tick240(4);
    n_cmp++; if (dut1.volume !== 4'd14) begin n_bad++;
      $display("FAIL env_step1: got %0d want 14", dut1.volume); end
    tick240(56);
    n_cmp++; if (dut1.volume !== 4'd0) begin n_bad++;
      $display("FAIL env_reach0: got %0d want 0", dut1.volume); end
    tick240(8);
    n_cmp++; if (dut1.volume !== 4'd0) begin n_bad++;
      $display("FAIL env_hold0: got %0d want 0", dut1.volume); end
    wr_reg(0, 8'h23);
    tick240(3);
    n_cmp++; if (dut1.volume !== 4'd0) begin n_bad++;
      $display("FAIL env_loop_wait: got %0d want 0", dut1.volume); end
    tick240(1);
    n_cmp++; if (dut1.volume !== 4'd15) begin n_bad++;
      $display("FAIL env_loop_wrap: got %0d want 15", dut1.volume); end
    wr_reg(0, 8'h13);
    n_cmp++; if (dut1.volume !== 4'd3) begin n_bad++;
      $display("FAIL env_const: got %0d want 3", dut1.volume); end
  endtask

  task automatic test_length();
    do_reset();
    set_chan_en(1'b1);
    wr_reg(0, 8'h00);
    wr_reg(3, 8'h08);
    n_cmp++; if (dut1.length_q !== 8'd254) begin n_bad++;
      $display("FAIL len_load: got %0d want 254", dut1.length_q); end
    @(negedge clk);
    set_chan_en(1'b0);
    #1;
    n_cmp++; if (bus1.active !== 1'b1) begin n_bad++;
      $display("FAIL len_off_same_clk: got %b want 1", bus1.active); end
    @(negedge clk);
    n_cmp++; if (bus1.active !== 1'b0) begin n_bad++;
      $display("FAIL len_off_next_clk: got %b want 0", bus1.active); end
    wr_reg(3, 8'h08);
    n_cmp++; if (dut1.length_q !== 8'd0) begin n_bad++;
      $display("FAIL len_wr_disabled: got %0d want 0", dut1.length_q); end
    set_chan_en(1'b1);
    wr_reg(0, 8'h20);
    wr_reg(3, 8'h08);
    tick120(3);
    n_cmp++; if (dut1.length_q !== 8'd254) begin n_bad++;
      $display("FAIL len_halt: got %0d want 254", dut1.length_q); end
    wr_reg(0, 8'h00);
    tick120(1);
    n_cmp++; if (dut1.length_q !== 8'd253) begin n_bad++;
      $display("FAIL len_decrement: got %0d want 253", dut1.length_q); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    bus1.enable_240hz = 1'b0; bus2.enable_240hz = 1'b0;
    bus1.enable_120hz = 1'b0; bus2.enable_120hz = 1'b0;
    bus1.chan_en = 1'b0;      bus2.chan_en = 1'b0;
    bus1.wr = 4'b0;           bus2.wr = 4'b0;
    bus1.din = 8'h00;         bus2.din = 8'h00;
    test_reset();
    test_duty();
    test_reset_mid_note();
    test_mute();
    test_sweep();
    test_envelope();
    test_length();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
